shift_add_multiplier: RTL
=========================

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiplication; sampled only in IDLE.
REQ-005 multiplicand  input  WIDTH  unsigned operand M; captured on accepted start.
REQ-006 multiplier  input  WIDTH  unsigned operand Q; captured on accepted start.
REQ-007 busy  output  1  high while an operation is in progress (CALC or DONE).
REQ-008 done  output  1  one-cycle pulse when product is valid.
REQ-009 product  output  2*WIDTH  unsigned M*Q result; holds until the next accepted start.

Function
REQ-010 FSM states: IDLE, CALC, DONE; encoding as a package enum.
REQ-011 IDLE: start=1 -> latch M, Q, clear accumulator A and carry C, load count=WIDTH, go to CALC; start=0 -> stay.
REQ-012 CALC, each cycle: if Q[0]=1 then {C,A}=A+M (WIDTH-bit add with carry-out), else {C,A}={0,A}; then shift {C,A,Q} right by 1; decrement count.
REQ-013 CALC -> DONE on the cycle count reaches 0 (exactly WIDTH add/shift steps).
REQ-014 DONE: product={A,Q}, done=1 for exactly one cycle, then unconditionally go to IDLE.
REQ-015 Latency: start sampled high at edge t -> done high in cycle following edge t+WIDTH+1; next start accepted at edge t+WIDTH+2.
REQ-016 Operands are unsigned; no overflow possible; carry-out of every add is retained via C, never dropped.
REQ-017 start while busy (CALC or DONE) is ignored; operand inputs may change freely while busy without effect.
REQ-018 start held high continuously -> back-to-back operations, one per WIDTH+2 cycles.
REQ-019 product updates only in DONE; unchanged in IDLE and CALC.
REQ-020 busy=0 and done=0 in IDLE.

Reset
REQ-021 rst=1 at any edge, including mid-CALC, forces IDLE, product=0, done=0, busy=0, A=0, Q=0, M=0, C=0, count=0.
REQ-022 rst takes priority over start in the same cycle; the operation is not accepted.
REQ-023 First start is accepted at the first edge after rst deasserts.

Structure
REQ-024 Shared package holds the FSM state enum and the default WIDTH constant.
REQ-025 One sub-module, mul_add_stage: combinational WIDTH-bit ripple adder (inputs A, M, cin=0; outputs sum, cout) instantiated once; shift and FSM logic stay in the top module.
REQ-026 No multiplication operator in RTL; product built only from add and shift.

Verification
REQ-027 M=13, Q=11, start pulse -> done after 9 cycles, product=0x008F (143), busy high 9 cycles.
REQ-028 M=255, Q=255 -> product=0xFE01 (65025); checks carry-out retention on every step.
REQ-029 M=0, Q=200 and M=200, Q=0 -> product=0x0000; M=1, Q=200 -> product=0x00C8.
REQ-030 Start M=7, Q=6; at cycle 3 pulse start with M=9, Q=9 -> first result 0x002A only, second start ignored, no second done.
REQ-031 Start M=100, Q=50; assert rst at cycle 4 for 1 cycle -> busy=0, done never pulses, product=0; next start M=3, Q=5 -> product=0x000F.
REQ-032 Random sweep of 1000 operand pairs, start held high -> each product equals M*Q, done period exactly WIDTH+2.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Holds the FSM state encoding and the default operand width.
package shift_add_multiplier_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_add_multiplier_add_stage.sv
// Combinational ripple-carry adder used for each partial-product step.
// Its carry-out is the C bit of the {C,A,Q} shift register.
module mul_add_stage
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] m,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i]       = a[i] ^ m[i] ^ carry[i];
      assign carry[i+1]   = (a[i] & m[i]) | (carry[i] & (a[i] ^ m[i]));
   end

   assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one conditional add plus right shift of
// {C,A,Q} per cycle, WIDTH steps, then the product is published in DONE.
module shift_add_multiplier
   import shift_add_multiplier_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [1:0]         state
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           st;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] m;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] sum;
   logic             cout;
   logic [WIDTH-1:0] add_a;
   logic             add_c;

   mul_add_stage #(.WIDTH(WIDTH)) u_add_stage (
      .a    (a),
      .m    (m),
      .cin  (1'b0),
      .sum  (sum),
      .cout (cout)
   );

   // C exists only between the add and the shift: it becomes A's new MSB.
   always_comb begin
      add_a = a;
      add_c = 1'b0;
      if (q[0]) begin
         add_a = sum;
         add_c = cout;
      end
   end

   assign state = st;

   always_ff @(posedge clk) begin
      if (rst) begin
         st      <= ST_IDLE;
         a       <= '0;
         q       <= '0;
         m       <= '0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         done <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (start) begin
                  m     <= multiplicand;
                  q     <= multiplier;
                  a     <= '0;
                  count <= CW'(WIDTH);
                  busy  <= 1'b1;
                  st    <= ST_CALC;
               end
            end
            ST_CALC: begin
               a     <= {add_c, add_a[WIDTH-1:1]};
               q     <= {add_a[0], q[WIDTH-1:1]};
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  st <= ST_DONE;
               end
            end
            ST_DONE: begin
               product <= {a, q};
               done    <= 1'b1;
               busy    <= 1'b0;
               st      <= ST_IDLE;
            end
            default: begin
               st   <= ST_IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
